// File: rtl/ca_row_engine.sv
// ca_row_engine
// Elementary 1-D cellular-automaton generator. Row 0 of the frame buffer is
// preloaded by the host. On start, rows 1..NUM_ROWS-1 are computed in order,
// each one from the row above, and written back through RAM port A.
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   start, rule         one-cycle start request (IDLE only), rule latched then
//   busy, done          busy while computing; done pulses once at the end
//   mem_address         port-A word address
//   mem_read/mem_write  command strobes (never both high)
//   mem_writedata       write data
//   mem_readdata        read data, valid one cycle after read acceptance
//   mem_waitrequest     stall: command not accepted this cycle
//
// Cell index k*WORD_W + j lives in word k, bit WORD_W-1-j (MSB is leftmost).
module ca_row_engine #(
    parameter int WORD_W        = 20,
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_ROW = 32,
    parameter int NUM_ROWS      = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rule,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_writedata,
    input  logic [WORD_W-1:0] mem_readdata,
    input  logic              mem_waitrequest
);

    localparam int K_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WORDS_PER_ROW);
    // Destination base of the final row; reaching it ends the screen.
    localparam logic [ADDR_W-1:0] LAST_DST = ADDR_W'((NUM_ROWS - 1) * WORDS_PER_ROW);
    // k value of the last word written from the WR state; the final word of
    // each row goes through LAST instead.
    localparam logic [K_W-1:0]    K_LAST   = K_W'(WORDS_PER_ROW - 2);

    typedef enum logic [2:0] {IDLE, RD0, CAP0, RD, CAP, WR, LAST, DONE} state_t;

    state_t            state, state_n;
    logic [7:0]        rule_q;
    logic [WORD_W-1:0] prev, cur, nxt;
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] src, dst;

    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic              right_in;
    logic [WORD_W+1:0] win;
    logic [WORD_W-1:0] next_word;

    assign rd_addr = src + ADDR_W'(k) + ADDR_W'(1);
    assign wr_addr = dst + ADDR_W'(k);

    // Neighbourhood window: left neighbour of the MSB cell is bit 0 of the
    // previous word, right neighbour of the LSB cell is the MSB of the next
    // word. prev is cleared at row start and the right side is forced to 0
    // in LAST, which gives the fixed zero edges.
    assign right_in = (state == LAST) ? 1'b0 : nxt[WORD_W-1];
    assign win      = {prev[0], cur, right_in};

    for (genvar b = 0; b < WORD_W; b++) begin : g_cell
        assign next_word[b] = rule_q[win[b+2 -: 3]];
    end

    always_comb begin
        state_n       = state;
        busy          = 1'b0;
        done          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state)
            IDLE: if (start) state_n = RD0;
            RD0: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = src;
                if (!mem_waitrequest) state_n = CAP0;
            end
            CAP0: begin
                busy    = 1'b1;
                state_n = RD;
            end
            RD: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = rd_addr;
                if (!mem_waitrequest) state_n = CAP;
            end
            CAP: begin
                busy    = 1'b1;
                state_n = WR;
            end
            WR: begin
                busy          = 1'b1;
                mem_write     = 1'b1;
                mem_address   = wr_addr;
                mem_writedata = next_word;
                if (!mem_waitrequest) state_n = (k == K_LAST) ? LAST : RD;
            end
            LAST: begin
                busy          = 1'b1;
                mem_write     = 1'b1;
                mem_address   = wr_addr;
                mem_writedata = next_word;
                if (!mem_waitrequest) state_n = (dst == LAST_DST) ? DONE : RD0;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            rule_q <= '0;
            prev   <= '0;
            cur    <= '0;
            nxt    <= '0;
            k      <= '0;
            src    <= '0;
            dst    <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    rule_q <= rule;
                    src    <= '0;
                    dst    <= ROW_STEP;
                end
                CAP0: begin
                    cur  <= mem_readdata;
                    prev <= '0;
                    k    <= '0;
                end
                CAP: nxt <= mem_readdata;
                WR: if (!mem_waitrequest) begin
                    prev <= cur;
                    cur  <= nxt;
                    k    <= k + K_W'(1);
                end
                LAST: if (!mem_waitrequest) begin
                    // Row just written becomes the source of the next one.
                    src <= dst;
                    dst <= dst + ROW_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_row_engine.sv
// Testbench for ca_row_engine. Runs a reduced screen (NR rows of full width)
// against a bench-side RAM, a cell-level reference model and a per-cycle
// monitor of the port-A command stream.
module tb_ca_row_engine;

    localparam int WW   = 20;
    localparam int AW   = 16;
    localparam int WPR  = 32;
    localparam int NR   = 12;
    localparam int NW   = NR * WPR;
    localparam int COLS = WPR * WW;
    // Unstalled figures for this geometry: 3*32*11, 32*11, 12*32-1.
    localparam int EXP_BUSY   = 1056;
    localparam int EXP_WRITES = 352;
    localparam int EXP_LAST   = 383;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rule = '0;
    logic          busy, done, mem_read, mem_write, waitrequest;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_writedata;
    logic [WW-1:0] readdata = '0;

    logic [WW-1:0] ram     [NW];
    logic [WW-1:0] exp_mem [NW];

    int n_tests = 0;
    int n_fail  = 0;

    // host access to the RAM (only the RAM process writes ram[])
    logic          host_clr = 1'b0;
    logic          host_we  = 1'b0;
    int            host_a   = 0;
    logic [WW-1:0] host_d   = '0;

    // stall injection: first rd_len read-command cycles after rd_sb stall
    int rd_cmd_cyc = 0, wr_cmd_cyc = 0;
    int rd_sb = 0, rd_len = 0, wr_sb = 0, wr_len = 0;

    // monitor counters
    int busy_cnt = 0, done_cnt = 0, wr_cnt = 0, wr_base = 0, last_addr = 0;

    always #5 clk = ~clk;

    ca_row_engine #(.WORD_W(WW), .ADDR_W(AW), .WORDS_PER_ROW(WPR), .NUM_ROWS(NR)) dut (
        .clk(clk), .reset(reset), .start(start), .rule(rule),
        .busy(busy), .done(done), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_readdata(readdata), .mem_waitrequest(waitrequest)
    );

    assign waitrequest = (mem_read  && (rd_cmd_cyc - rd_sb) < rd_len) ||
                         (mem_write && (wr_cmd_cyc - wr_sb) < wr_len);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // RAM: port A for the DUT plus host preload
    always @(posedge clk) begin
        if (host_clr) begin
            for (int i = 0; i < NW; i++) ram[i] <= '0;
        end else if (host_we) begin
            ram[host_a] <= host_d;
        end else if (mem_write && !waitrequest && int'(mem_address) < NW) begin
            ram[mem_address] <= mem_writedata;
        end
        if (mem_read && !waitrequest && int'(mem_address) < NW) readdata <= ram[mem_address];
        if (mem_read)  rd_cmd_cyc <= rd_cmd_cyc + 1;
        if (mem_write) wr_cmd_cyc <= wr_cmd_cyc + 1;
    end

    // Compare process: command rules and every accepted write against the model
    logic          p_held = 1'b0, p_rd = 1'b0, p_wr = 1'b0, p_busy = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [WW-1:0] p_data = '0;
    always @(negedge clk) begin
        if (!reset) begin
            p_held = 1'b0;
            p_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (mem_read && mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);
            if (mem_read || mem_write) check("addr_range", 32'(int'(mem_address) < NW), 32'd1);
            if (p_held) begin
                check("stall_cmd",  {30'd0, mem_read, mem_write}, {30'd0, p_rd, p_wr});
                check("stall_addr", 32'(mem_address), 32'(p_addr));
                check("stall_data", 32'(mem_writedata), 32'(p_data));
            end
            if (mem_write && !waitrequest) begin
                check("wr_addr", 32'(mem_address), 32'(WPR + wr_cnt - wr_base));
                if (int'(mem_address) < NW)
                    check("wr_data", 32'(mem_writedata), 32'(exp_mem[mem_address]));
                last_addr = int'(mem_address);
                wr_cnt++;
            end
            if (p_busy && !busy) check("done_after_busy", 32'(done), 32'd1);
            p_held = (mem_read || mem_write) && waitrequest;
            p_rd   = mem_read;
            p_wr   = mem_write;
            p_addr = mem_address;
            p_data = mem_writedata;
            p_busy = busy;
        end
    end

    // Reference model: whole screen from row 0 as a flat line of cells
    task automatic build_model(input logic [7:0] rl);
        logic [COLS-1:0] c, n;
        logic l, r;
        for (int i = 0; i < COLS; i++) c[i] = ram[i / WW][WW - 1 - (i % WW)];
        for (int w = 0; w < WPR; w++) exp_mem[w] = ram[w];
        for (int row = 1; row < NR; row++) begin
            for (int i = 0; i < COLS; i++) begin
                l = (i == 0) ? 1'b0 : c[i-1];
                r = (i == COLS - 1) ? 1'b0 : c[i+1];
                n[i] = rl[{l, c[i], r}];
            end
            for (int i = 0; i < COLS; i++) exp_mem[row*WPR + i/WW][WW - 1 - (i % WW)] = n[i];
            c = n;
        end
    endtask

    task automatic check_rows(input int lo, input int hi);
        int idx;
        for (int row = lo; row <= hi; row++) begin
            idx = row * WPR;
            for (int w = WPR - 1; w >= 0; w--)
                if (ram[row*WPR + w] !== exp_mem[row*WPR + w]) idx = row*WPR + w;
            check($sformatf("ram_row%0d_word%0d", row, idx - row*WPR), 32'(ram[idx]), 32'(exp_mem[idx]));
        end
    endtask

    task automatic host_clear();
        @(negedge clk) host_clr = 1'b1;
        @(negedge clk) host_clr = 1'b0;
    endtask

    task automatic host_wr(input int a, input logic [WW-1:0] d);
        @(negedge clk);
        host_we = 1'b1; host_a = a; host_d = d;
        @(negedge clk) host_we = 1'b0;
    endtask

    task automatic run_engine(input logic [7:0] r, input int mid_at,
                              input logic [7:0] mid_rule, output int busy_n);
        int b0, d0, cyc;
        b0 = busy_cnt; d0 = done_cnt; wr_base = wr_cnt;
        @(negedge clk); start = 1'b1; rule = r;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 5000) begin
            if (mid_at > 0 && cyc == mid_at) begin
                start = 1'b1; rule = mid_rule;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 5000) check("run_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge clk);
        busy_n = busy_cnt - b0;
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bn, cyc;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_read",  32'(mem_read), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_addr",  32'(mem_address), 32'd0);
        check("rst_wdata", 32'(mem_writedata), 32'd0);
        reset = 1'b1;

        // 1: rule 90, single cell 19; also the unstalled timing figures
        host_clear(); host_wr(0, 20'h00001); build_model(8'd90);
        check("model_r1w0", 32'(exp_mem[WPR]), 32'h00002);
        check("model_r1w1", 32'(exp_mem[WPR+1]), 32'h80000);
        check("model_r2w0", 32'(exp_mem[2*WPR]), 32'h00004);
        check("model_r2w1", 32'(exp_mem[2*WPR+1]), 32'h40000);
        run_engine(8'd90, 0, 8'd0, bn);
        check("s1_busy_cycles", 32'(bn), 32'(EXP_BUSY));
        check("s1_writes", 32'(wr_cnt - wr_base), 32'(EXP_WRITES));
        check("s1_last_addr", 32'(last_addr), 32'(EXP_LAST));
        check("s1_ram_r1w0", 32'(ram[WPR]), 32'h00002);
        check("s1_ram_r1w1", 32'(ram[WPR+1]), 32'h80000);
        check_rows(1, NR - 1);

        // 2: cell 0 only, left edge does not wrap
        host_clear(); host_wr(0, 20'h80000); build_model(8'd90);
        check("model_s2_r1w0", 32'(exp_mem[WPR]), 32'h40000);
        run_engine(8'd90, 0, 8'd0, bn);
        check("s2_ram_r1w0", 32'(ram[WPR]), 32'h40000);
        check("s2_ram_r1w31", 32'(ram[2*WPR-1]), 32'h00000);
        check_rows(1, NR - 1);

        // 3: rule 255 then rule 0 on an empty row 0
        host_clear(); build_model(8'd255);
        run_engine(8'd255, 0, 8'd0, bn);
        check("s3_ram_r5w7", 32'(ram[5*WPR+7]), 32'hFFFFF);
        check("s3_ram_lastword", 32'(ram[NW-1]), 32'hFFFFF);
        check_rows(1, NR - 1);
        build_model(8'd0);
        run_engine(8'd0, 0, 8'd0, bn);
        check("s3_ram_zero", 32'(ram[3*WPR+4]), 32'h00000);
        check_rows(1, NR - 1);

        // 5: stalls of 5 cycles on the first read and 3 on the first write
        host_clear(); host_wr(0, 20'h00001); build_model(8'd90);
        rd_sb = rd_cmd_cyc; rd_len = 5; wr_sb = wr_cmd_cyc; wr_len = 3;
        run_engine(8'd90, 0, 8'd0, bn);
        rd_len = 0; wr_len = 0;
        check("s5_busy_cycles", 32'(bn), 32'(EXP_BUSY + 8));
        check("s5_ram_r1w0", 32'(ram[WPR]), 32'h00002);
        check_rows(1, NR - 1);

        // 6: reset during row 3, then a start pulsed while busy is ignored
        build_model(8'd30);
        check("model_s6_r1w0", 32'(exp_mem[WPR]), 32'h00003);
        wr_base = wr_cnt;
        @(negedge clk); start = 1'b1; rule = 8'd30;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while ((wr_cnt - wr_base) < 2*WPR + 5 && cyc < 5000) begin
            @(negedge clk); cyc++;
        end
        if (cyc >= 5000) check("s6_reach_row3_timeout", 32'd1, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        check("abort_read",  32'(mem_read), 32'd0);
        check("abort_write", 32'(mem_write), 32'd0);
        check("abort_addr",  32'(mem_address), 32'd0);
        check("abort_wdata", 32'(mem_writedata), 32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        check_rows(1, 2);
        run_engine(8'd30, 200, 8'd150, bn);
        check("s6_busy_cycles", 32'(bn), 32'(EXP_BUSY));
        check_rows(1, NR - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
